// File: rtl/whg_pkg.sv
// Shared types and constants for the collision-checker slice.
package whg_pkg;

    localparam int COORD_W     = 10;
    localparam int MAX_CIRCLES = 16;
    localparam int IDX_W       = $clog2(MAX_CIRCLES);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SCAN   = 2'd1,
        ST_FINISH = 2'd2
    } scan_state_t;

    // One extra bit so distances and sums never wrap.
    function automatic logic [COORD_W:0] abs_diff(input logic [COORD_W-1:0] a,
                                                  input logic [COORD_W-1:0] b);
        return (a >= b) ? {1'b0, a - b} : {1'b0, b - a};
    endfunction

endpackage

// File: rtl/circle_hit_test.sv
// Player-box versus one circle overlap test.
// CIRCLE_EXACT_HIT_EN selects the registered exact-distance test instead of the box test.
module circle_hit_test
    import whg_pkg::*;
(
`ifdef CIRCLE_EXACT_HIT_EN
    input  logic               Clk,
    input  logic               Reset,
`endif
    input  logic [COORD_W-1:0] cx,
    input  logic [COORD_W-1:0] cy,
    input  logic [COORD_W-1:0] cs,
    input  logic [COORD_W-1:0] px,
    input  logic [COORD_W-1:0] py,
    input  logic [COORD_W-1:0] ps,
    output logic               collide
);

    logic [COORD_W:0] dx_s;
    logic [COORD_W:0] dy_s;

    assign dx_s = abs_diff(px, cx);
    assign dy_s = abs_diff(py, cy);

`ifdef CIRCLE_EXACT_HIT_EN
    logic [COORD_W:0] ex_s;
    logic [COORD_W:0] ey_s;
    logic [21:0]      dist2_s;
    logic [21:0]      rad2_s;

    // Distance from the circle centre to the nearest point of the player box.
    always_comb begin
        ex_s    = (dx_s > {1'b0, ps}) ? dx_s - {1'b0, ps} : 11'd0;
        ey_s    = (dy_s > {1'b0, ps}) ? dy_s - {1'b0, ps} : 11'd0;
        dist2_s = ({11'd0, ex_s} * {11'd0, ex_s}) + ({11'd0, ey_s} * {11'd0, ey_s});
        rad2_s  = {12'd0, cs} * {12'd0, cs};
    end

    // Compare result lands one cycle after its circle is presented.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            collide <= 1'b0;
        end else begin
            collide <= (dist2_s <= rad2_s);
        end
    end
`else
    logic [COORD_W:0] reach_s;

    // Box approximation: both axis distances within the combined extents.
    always_comb begin
        reach_s = {1'b0, ps} + {1'b0, cs};
        collide = (dx_s <= reach_s) && (dy_s <= reach_s);
    end
`endif

endmodule

// File: rtl/circle_collision.sv
// Per-frame sequential scan of all circles against the player, with a saturating death counter.
// CIRCLE_EXACT_HIT_EN adds a one-cycle drain for the registered exact test.
module circle_collision
    import whg_pkg::*;
#(
    parameter int N_CIRCLES = 8,
    parameter int DEATH_W   = 16
) (
    input  logic                                Clk,
    input  logic                                Reset,
    input  logic                                frame_start,
    input  logic                                enable,
    input  logic [N_CIRCLES-1:0][COORD_W-1:0]   CircleX,
    input  logic [N_CIRCLES-1:0][COORD_W-1:0]   CircleY,
    input  logic [N_CIRCLES-1:0][COORD_W-1:0]   CircleS,
    input  logic [COORD_W-1:0]                  PlayerX,
    input  logic [COORD_W-1:0]                  PlayerY,
    input  logic [COORD_W-1:0]                  PlayerS,
    output logic                                busy,
    output logic                                done,
    output logic                                hit,
    output logic [3:0]                          hit_index,
    output logic [DEATH_W-1:0]                  death_count
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_CIRCLES - 1);

    scan_state_t         state_r;
    logic [IDX_W-1:0]    idx_r;
    logic [COORD_W-1:0]  px_r, py_r, ps_r;
    logic                scan_hit_r;
    logic [IDX_W-1:0]    scan_idx_r;
    logic [COORD_W-1:0]  cx_s, cy_s, cs_s;
    logic                collide_s;
`ifdef CIRCLE_EXACT_HIT_EN
    logic                pend_valid_r;
    logic [IDX_W-1:0]    pend_idx_r;
    logic                drain_r;
`endif

    // Select the circle at the scan index.
    always_comb begin
        cx_s = {COORD_W{1'b0}};
        cy_s = {COORD_W{1'b0}};
        cs_s = {COORD_W{1'b0}};
        for (int i = 0; i < N_CIRCLES; i++) begin
            cx_s = cx_s | (CircleX[i] & {COORD_W{idx_r == IDX_W'(i)}});
            cy_s = cy_s | (CircleY[i] & {COORD_W{idx_r == IDX_W'(i)}});
            cs_s = cs_s | (CircleS[i] & {COORD_W{idx_r == IDX_W'(i)}});
        end
    end

    circle_hit_test u_hit (
`ifdef CIRCLE_EXACT_HIT_EN
        .Clk     (Clk),
        .Reset   (Reset),
`endif
        .cx      (cx_s),
        .cy      (cy_s),
        .cs      (cs_s),
        .px      (px_r),
        .py      (py_r),
        .ps      (ps_r),
        .collide (collide_s)
    );

    // Scan FSM, first-hit capture, published result and death counter.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_r      <= ST_IDLE;
            idx_r        <= {IDX_W{1'b0}};
            px_r         <= {COORD_W{1'b0}};
            py_r         <= {COORD_W{1'b0}};
            ps_r         <= {COORD_W{1'b0}};
            scan_hit_r   <= 1'b0;
            scan_idx_r   <= {IDX_W{1'b0}};
            busy         <= 1'b0;
            done         <= 1'b0;
            hit          <= 1'b0;
            hit_index    <= 4'd0;
            death_count  <= {DEATH_W{1'b0}};
`ifdef CIRCLE_EXACT_HIT_EN
            pend_valid_r <= 1'b0;
            pend_idx_r   <= {IDX_W{1'b0}};
            drain_r      <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (frame_start && enable) begin
                        px_r       <= PlayerX;
                        py_r       <= PlayerY;
                        ps_r       <= PlayerS;
                        idx_r      <= {IDX_W{1'b0}};
                        scan_hit_r <= 1'b0;
                        scan_idx_r <= {IDX_W{1'b0}};
                        busy       <= 1'b1;
                        state_r    <= ST_SCAN;
`ifdef CIRCLE_EXACT_HIT_EN
                        pend_valid_r <= 1'b0;
                        drain_r      <= 1'b0;
`endif
                    end else begin
                        busy <= 1'b0;
                    end
                end
                ST_SCAN: begin
`ifdef CIRCLE_EXACT_HIT_EN
                    // collide_s belongs to the circle presented on the previous cycle.
                    if (pend_valid_r && collide_s && !scan_hit_r) begin
                        scan_hit_r <= 1'b1;
                        scan_idx_r <= pend_idx_r;
                    end
                    pend_idx_r   <= idx_r;
                    pend_valid_r <= !drain_r;
                    if (drain_r) begin
                        drain_r <= 1'b0;
                        busy    <= 1'b0;
                        state_r <= ST_FINISH;
                    end else if (idx_r == LAST_IDX) begin
                        drain_r <= 1'b1;
                    end else begin
                        idx_r <= idx_r + IDX_W'(1);
                    end
`else
                    if (collide_s && !scan_hit_r) begin
                        scan_hit_r <= 1'b1;
                        scan_idx_r <= idx_r;
                    end
                    if (idx_r == LAST_IDX) begin
                        busy    <= 1'b0;
                        state_r <= ST_FINISH;
                    end else begin
                        idx_r <= idx_r + IDX_W'(1);
                    end
`endif
                end
                ST_FINISH: begin
                    hit       <= scan_hit_r;
                    hit_index <= 4'(scan_idx_r);
                    done      <= 1'b1;
                    if (scan_hit_r && (death_count != {DEATH_W{1'b1}})) begin
                        death_count <= death_count + DEATH_W'(1);
                    end
                    state_r <= ST_IDLE;
                end
                default: begin
                    busy    <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_circle_collision.sv
// Scoreboard bench for circle_collision: directed frames push expectations, a monitor checks each done.
module tb_circle_collision;

    localparam int N  = 8;
`ifdef CIRCLE_EXACT_HIT_EN
    localparam int LAT = N + 3;
`else
    localparam int LAT = N + 2;
`endif

    logic                 Clk = 1'b0;
    logic                 Reset = 1'b1;
    logic                 frame_start = 1'b0;
    logic                 enable = 1'b0;
    logic [N-1:0][9:0]    CircleX, CircleY, CircleS;
    logic [9:0]           PlayerX = 10'd0, PlayerY = 10'd0, PlayerS = 10'd0;
    logic                 busy, done, hit;
    logic [3:0]           hit_index;
    logic [15:0]          death_count;
    logic                 busy2, done2, hit2;
    logic [3:0]           hit_index2;
    logic [1:0]           death_count2;

    circle_collision #(.N_CIRCLES(N), .DEATH_W(16)) dut (
        .Clk(Clk), .Reset(Reset), .frame_start(frame_start), .enable(enable),
        .CircleX(CircleX), .CircleY(CircleY), .CircleS(CircleS),
        .PlayerX(PlayerX), .PlayerY(PlayerY), .PlayerS(PlayerS),
        .busy(busy), .done(done), .hit(hit), .hit_index(hit_index), .death_count(death_count)
    );

    // Narrow counter copy to reach saturation within a few frames.
    circle_collision #(.N_CIRCLES(N), .DEATH_W(2)) dut_sat (
        .Clk(Clk), .Reset(Reset), .frame_start(frame_start), .enable(enable),
        .CircleX(CircleX), .CircleY(CircleY), .CircleS(CircleS),
        .PlayerX(PlayerX), .PlayerY(PlayerY), .PlayerS(PlayerS),
        .busy(busy2), .done(done2), .hit(hit2), .hit_index(hit_index2), .death_count(death_count2)
    );

    always #5 Clk = ~Clk;

    int cyc = 0;
    always @(posedge Clk) cyc <= cyc + 1;

    typedef struct {
        int px, py, ps;
        int ia, ax, ay, as_;
        int ib, bx, by, bs;
        bit hit;
        int idx;
    } vec_t;

    typedef struct {
        bit hit;
        int idx;
        int death;
        int sat;
        int at_cyc;
    } exp_t;

    vec_t vecs[10];
    exp_t sb[$];
    int   checks = 0;
    int   failures = 0;
    int   pushed = 0;
    int   dones_seen = 0;
    int   exp_death = 0;
    int   exp_sat = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Load a vector onto the inputs, raise frame_start and record the expected result.
    task automatic issue(input int v);
        exp_t e;
        for (int i = 0; i < N; i++) begin
            CircleX[i] = 10'd900;
            CircleY[i] = 10'd900;
            CircleS[i] = 10'd1;
        end
        PlayerX = 10'(vecs[v].px);
        PlayerY = 10'(vecs[v].py);
        PlayerS = 10'(vecs[v].ps);
        if (vecs[v].ia >= 0) begin
            CircleX[vecs[v].ia] = 10'(vecs[v].ax);
            CircleY[vecs[v].ia] = 10'(vecs[v].ay);
            CircleS[vecs[v].ia] = 10'(vecs[v].as_);
        end
        if (vecs[v].ib >= 0) begin
            CircleX[vecs[v].ib] = 10'(vecs[v].bx);
            CircleY[vecs[v].ib] = 10'(vecs[v].by);
            CircleS[vecs[v].ib] = 10'(vecs[v].bs);
        end
        enable = 1'b1;
        frame_start = 1'b1;
        if (vecs[v].hit) begin
            exp_death = (exp_death == 65535) ? 65535 : exp_death + 1;
            exp_sat   = (exp_sat == 3) ? 3 : exp_sat + 1;
        end
        e.hit    = vecs[v].hit;
        e.idx    = vecs[v].hit ? vecs[v].idx : 0;
        e.death  = exp_death;
        e.sat    = exp_sat;
        e.at_cyc = cyc + LAT;
        sb.push_back(e);
        pushed++;
    endtask

    // Wait at negedges until done is seen, bounded.
    task automatic wait_done(input string name);
        bit got = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (done) begin
                got = 1'b1;
                break;
            end
            @(negedge Clk);
        end
        if (!got) begin
            checks++;
            failures++;
            $display("FAIL %s: done not seen within 40 cycles", name);
        end
    endtask

    // Monitor: pop and compare on every done.
    initial begin
        exp_t e;
        forever begin
            @(negedge Clk);
            if (!Reset && done) begin
                dones_seen++;
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_done: got done at cycle %0d expected none", cyc);
                end else begin
                    e = sb.pop_front();
                    chk("latency_cycle", cyc, e.at_cyc);
                    chk("hit", int'(hit), int'(e.hit));
                    chk("hit_index", int'(hit_index), e.idx);
                    chk("death_count", int'(death_count), e.death);
                    chk("death_count_sat", int'(death_count2), e.sat);
                    chk("busy_at_done", int'(busy), 0);
                end
            end
        end
    end

    initial begin
        //           px  py  ps    ia ax  ay  as    ib bx  by  bs  hit idx
        vecs[0] = '{100, 100, 4,   0, 106, 100, 3, -1, 0, 0, 0,   1'b1, 0};
        vecs[1] = '{100, 100, 4,   5, 107, 100, 3, -1, 0, 0, 0,   1'b1, 5};
        vecs[2] = '{100, 100, 4,   5, 108, 100, 3, -1, 0, 0, 0,   1'b0, 0};
        vecs[3] = '{100, 100, 4,   2, 98,  103, 2,  6, 100, 100, 5, 1'b1, 2};
        vecs[4] = '{100, 100, 4,  -1, 0,   0,   0, -1, 0, 0, 0,   1'b0, 0};
`ifdef CIRCLE_EXACT_HIT_EN
        vecs[5] = '{100, 100, 4,   7, 95,  95,  1, -1, 0, 0, 0,   1'b0, 0};
        vecs[7] = '{100, 100, 4,   3, 107, 107, 3, -1, 0, 0, 0,   1'b0, 0};
`else
        vecs[5] = '{100, 100, 4,   7, 95,  95,  1, -1, 0, 0, 0,   1'b1, 7};
        vecs[7] = '{100, 100, 4,   3, 107, 107, 3, -1, 0, 0, 0,   1'b1, 3};
`endif
        vecs[6] = '{100, 100, 4,   1, 106, 106, 3, -1, 0, 0, 0,   1'b1, 1};
        vecs[8] = '{0,   0, 1023,  0, 1023, 1023, 1023, -1, 0, 0, 0, 1'b1, 0};
        vecs[9] = '{2,   2,   4,   4, 0,   0,   0, -1, 0, 0, 0,   1'b1, 4};

        for (int i = 0; i < N; i++) begin
            CircleX[i] = 10'd900;
            CircleY[i] = 10'd900;
            CircleS[i] = 10'd1;
        end

        repeat (2) @(negedge Clk);
        chk("reset_busy", int'(busy), 0);
        chk("reset_done", int'(done), 0);
        chk("reset_hit", int'(hit), 0);
        chk("reset_hit_index", int'(hit_index), 0);
        chk("reset_death_count", int'(death_count), 0);
        Reset = 1'b0;
        @(negedge Clk);

        // Directed frames, back-to-back after each done.
        for (int v = 0; v < 10; v++) begin
            issue(v);
            @(negedge Clk);
            frame_start = 1'b0;
            chk("busy_during_scan", int'(busy), 1);
            wait_done($sformatf("frame_%0d", v));
        end

        // Restarts mid-scan, enable dropped mid-scan, and a disabled start: only one done.
        issue(0);
        @(negedge Clk);
        frame_start = 1'b0;
        repeat (2) @(negedge Clk);
        frame_start = 1'b1;
        @(negedge Clk);
        frame_start = 1'b0;
        enable = 1'b0;
        wait_done("midscan_frame");
        frame_start = 1'b1;
        @(negedge Clk);
        frame_start = 1'b0;
        chk("disabled_start_busy", int'(busy), 0);
        repeat (15) @(negedge Clk);

        // Reset in the middle of a scan (idx 3): outputs return to zero, no done.
        enable = 1'b1;
        frame_start = 1'b1;
        @(negedge Clk);
        frame_start = 1'b0;
        repeat (3) @(negedge Clk);
        chk("busy_before_reset", int'(busy), 1);
        Reset = 1'b1;
        #1;
        chk("midreset_busy", int'(busy), 0);
        chk("midreset_done", int'(done), 0);
        chk("midreset_hit", int'(hit), 0);
        chk("midreset_hit_index", int'(hit_index), 0);
        chk("midreset_death_count", int'(death_count), 0);
        exp_death = 0;
        exp_sat = 0;
        @(negedge Clk);
        Reset = 1'b0;
        repeat (15) @(negedge Clk);

        issue(3);
        @(negedge Clk);
        frame_start = 1'b0;
        wait_done("post_reset_frame");
        repeat (3) @(negedge Clk);

        chk("scoreboard_empty", sb.size(), 0);
        chk("done_count", dones_seen, pushed);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
